// File: rtl/fifo_biquad_stage.sv
// ---------------------------------------------------------------------------
// fifo_biquad_stage
//
// Purpose:
//   Pops 16-bit samples from an upstream synchronous FIFO and runs one
//   direct-form-I biquad section. It is one section of a Chebyshev cascade.
//   A single multiplier is shared across the five taps, which are evaluated
//   one after another. Each result is presented on a valid/ready output port.
//   The FIFO absorbs all backpressure, because a new sample is popped only
//   after the previous result has been accepted downstream.
//
//   y[n] = clip16((8192 + B0*x[n] + B1*x[n-1] + B2*x[n-2]
//                       - A1*y[n-1] - A2*y[n-2]) >>> 14)
//   All coefficients are signed Q2.14.
//
// Configuration macro:
//   BIQUAD_SAT_EN  defined   -> clip16 saturates to [-32768, 32767].
//                               sat_flag records any clipped output (sticky).
//                  undefined -> clip16 keeps the low 16 bits (wraps).
//                               sat_flag is tied to 0.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   clr         in   synchronous clear of history/acc/FSM/sat_flag
//   fifo_empty  in   upstream FIFO empty flag
//   fifo_rd_cs  out  FIFO read chip select (same as fifo_rd_en)
//   fifo_rd_en  out  FIFO pop, one-cycle pulse (combinational in IDLE)
//   fifo_data   in   FIFO read data, valid the cycle after the pop edge
//   out_data    out  filtered sample, signed, stable while out_valid=1
//   out_valid   out  out_data valid
//   out_ready   in   downstream accept
//   busy        out  FSM not in IDLE
//   sat_flag    out  sticky clip indicator (saturating build only)
// ---------------------------------------------------------------------------
module fifo_biquad_stage #(
  parameter logic signed [15:0] B0 = 16'sd4096,
  parameter logic signed [15:0] B1 = 16'sd8192,
  parameter logic signed [15:0] B2 = 16'sd4096,
  parameter logic signed [15:0] A1 = 16'sd0,
  parameter logic signed [15:0] A2 = 16'sd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        fifo_empty,
  output logic        fifo_rd_cs,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_data,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        sat_flag
);

  typedef enum logic [3:0] {
    S_IDLE, S_CAPT, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4, S_OUT, S_HOLD
  } state_t;

  // The feedback taps are subtracted, so the negated coefficients are stored.
  // They are held in 17 bits so that -(-32768) is still representable.
  localparam logic signed [16:0] NEG_A1 = -$signed({A1[15], A1});
  localparam logic signed [16:0] NEG_A2 = -$signed({A2[15], A2});

  state_t state_reg, state_next;

  logic signed [15:0] x0_reg, x1_reg, x2_reg, y1_reg, y2_reg;
  logic signed [35:0] acc_reg;
  logic [15:0]        out_data_reg;
  logic               out_valid_reg;
  logic               pop;

  logic signed [16:0] coef;
  logic signed [15:0] operand;
  logic signed [32:0] product;
  logic signed [35:0] rounded;
  logic signed [15:0] clipped;

  // Tap select for the shared multiplier.
  always_comb begin
    coef    = '0;
    operand = '0;
    case (state_reg)
      S_MAC0: begin coef = {B0[15], B0}; operand = x0_reg; end
      S_MAC1: begin coef = {B1[15], B1}; operand = x1_reg; end
      S_MAC2: begin coef = {B2[15], B2}; operand = x2_reg; end
      S_MAC3: begin coef = NEG_A1;       operand = y1_reg; end
      S_MAC4: begin coef = NEG_A2;       operand = y2_reg; end
      default: ;
    endcase
  end

  assign product = 33'(coef) * 33'(operand);
  assign rounded = acc_reg >>> 14;

`ifdef BIQUAD_SAT_EN
  logic clip_hit;
  logic sat_reg;

  always_comb begin
    clip_hit = 1'b0;
    clipped  = rounded[15:0];
    if (rounded > 36'sd32767) begin
      clipped  = 16'sh7fff;
      clip_hit = 1'b1;
    end else if (rounded < -36'sd32768) begin
      clipped  = 16'sh8000;
      clip_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_reg <= 1'b0;
    end else if (clr) begin
      sat_reg <= 1'b0;
    end else if (state_reg == S_OUT && clip_hit) begin
      sat_reg <= 1'b1;
    end
  end

  assign sat_flag = sat_reg;
`else
  // The wrapping build keeps the low 16 bits and drops the upper bits.
  logic unused_rounded;
  assign unused_rounded = ^rounded[35:16];
  assign clipped  = rounded[15:0];
  assign sat_flag = 1'b0;
`endif

  // Next state and pop request.
  // A pop is never issued while clr is high, because clr forces IDLE anyway.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty && !out_valid_reg && !clr) begin
          pop        = 1'b1;
          state_next = S_CAPT;
        end
      end
      S_CAPT: state_next = S_MAC0;
      S_MAC0: state_next = S_MAC1;
      S_MAC1: state_next = S_MAC2;
      S_MAC2: state_next = S_MAC3;
      S_MAC3: state_next = S_MAC4;
      S_MAC4: state_next = S_OUT;
      S_OUT:  state_next = S_HOLD;
      S_HOLD: if (out_valid_reg && out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      x0_reg        <= '0;
      x1_reg        <= '0;
      x2_reg        <= '0;
      y1_reg        <= '0;
      y2_reg        <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (clr) begin
      state_reg     <= S_IDLE;
      x0_reg        <= '0;
      x1_reg        <= '0;
      x2_reg        <= '0;
      y1_reg        <= '0;
      y2_reg        <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_CAPT: begin
          x0_reg  <= fifo_data;
          acc_reg <= 36'sd8192;  // half LSB of the >>>14, rounds ties upward
        end
        S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4: begin
          acc_reg <= acc_reg + 36'(product);
        end
        S_OUT: begin
          out_data_reg  <= clipped;
          out_valid_reg <= 1'b1;
          x2_reg        <= x1_reg;
          x1_reg        <= x0_reg;
          y2_reg        <= y1_reg;
          y1_reg        <= clipped;  // feedback uses the post-clip value
        end
        S_HOLD: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The pop is a combinational output, so it is also masked while rst is high.
  assign fifo_rd_en = pop & ~rst;
  assign fifo_rd_cs = fifo_rd_en;
  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_fifo_biquad_stage.sv
`timescale 1ns/1ps
module tb_fifo_biquad_stage;

  localparam int NL = 5;
  // lane 0 default, 1 passthrough, 2 feedback, 3 saturation, 4 all taps active
  localparam logic signed [15:0] CB0 [NL] = '{16'sd4096, 16'sd16384, 16'sd16384, 16'sd16384, 16'sd3000};
  localparam logic signed [15:0] CB1 [NL] = '{16'sd8192, 16'sd0, 16'sd0, 16'sd16384, -16'sd5000};
  localparam logic signed [15:0] CB2 [NL] = '{16'sd4096, 16'sd0, 16'sd0, 16'sd16384, 16'sd2500};
  localparam logic signed [15:0] CA1 [NL] = '{16'sd0, 16'sd0, -16'sd8192, 16'sd0, -16'sd12000};
  localparam logic signed [15:0] CA2 [NL] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd6000};

`ifdef BIQUAD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [NL-1:0] fifo_empty, fifo_rd_cs, fifo_rd_en, out_valid, busy, sat_flag;
  logic [NL-1:0] out_ready = '0;
  logic [15:0]   fifo_data [NL] = '{default: 16'd0};
  logic [15:0]   out_data [NL];

  for (genvar gi = 0; gi < NL; gi++) begin : g_dut
    fifo_biquad_stage #(
      .B0(CB0[gi]), .B1(CB1[gi]), .B2(CB2[gi]), .A1(CA1[gi]), .A2(CA2[gi])
    ) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .fifo_empty(fifo_empty[gi]), .fifo_rd_cs(fifo_rd_cs[gi]),
      .fifo_rd_en(fifo_rd_en[gi]), .fifo_data(fifo_data[gi]),
      .out_data(out_data[gi]), .out_valid(out_valid[gi]),
      .out_ready(out_ready[gi]), .busy(busy[gi]), .sat_flag(sat_flag[gi])
    );
  end

  // ---------------- upstream FIFO model ----------------
  logic [15:0] fmem [NL][256];
  logic [7:0]  head [NL] = '{default: 8'd0};
  logic [7:0]  tail [NL] = '{default: 8'd0};

  always_comb begin
    fifo_empty = '0;
    for (int l = 0; l < NL; l++) fifo_empty[l] = (head[l] == tail[l]);
  end

  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (fifo_rd_en[l] && head[l] != tail[l]) begin
        fifo_data[l] <= fmem[l][head[l]];
        head[l]      <= head[l] + 8'd1;
      end
    end
  end

  task automatic push(input int l, input logic signed [15:0] v);
    fmem[l][tail[l]] = v;
    tail[l] = tail[l] + 8'd1;
  endtask

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  logic signed [63:0] mx1 [NL], mx2 [NL], my1 [NL], my2 [NL], mexp [NL];
  bit  mpend [NL], msat [NL], prev_valid [NL], prev_acc [NL];
  int  pop_cyc [NL], pop_cnt [NL], out_cnt [NL];
  logic signed [63:0] out_log [NL][64];
  int  cyc = 0;

  initial begin
    for (int l = 0; l < NL; l++) begin
      pop_cnt[l] = 0;
      out_cnt[l] = 0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      logic signed [63:0] x, sum, r, y;
      bit hit;
      if (rst) begin
        mx1[l] <= 0; mx2[l] <= 0; my1[l] <= 0; my2[l] <= 0;
        mpend[l] <= 1'b0; msat[l] <= 1'b0; prev_valid[l] <= 1'b0; prev_acc[l] <= 1'b0;
      end else if (clr) begin
        check($sformatf("clr_pop_suppressed_l%0d", l), fifo_rd_en[l], 0);
        mx1[l] <= 0; mx2[l] <= 0; my1[l] <= 0; my2[l] <= 0;
        mpend[l] <= 1'b0; msat[l] <= 1'b0; prev_valid[l] <= 1'b0; prev_acc[l] <= 1'b0;
      end else begin
        if (prev_valid[l] && !prev_acc[l])
          check($sformatf("hold_valid_l%0d", l), out_valid[l], 1);
        if (out_valid[l] && !prev_valid[l]) begin
          if (mpend[l]) check($sformatf("latency_l%0d", l), cyc - pop_cyc[l], 8);
          else          check($sformatf("valid_without_pop_l%0d", l), 1, 0);
        end
        if (fifo_rd_cs[l] && !fifo_rd_en[l]) check($sformatf("rd_cs_l%0d", l), fifo_rd_cs[l], fifo_rd_en[l]);
        if (fifo_rd_en[l]) begin
          check($sformatf("pop_when_busy_l%0d", l), {out_valid[l], busy[l], mpend[l]}, 0);
          check($sformatf("pop_when_empty_l%0d", l), fifo_empty[l], 0);
          check($sformatf("rd_cs_with_en_l%0d", l), fifo_rd_cs[l], 1);
          x   = $signed(fmem[l][head[l]]);
          sum = 64'sd8192 + CB0[l] * x + CB1[l] * mx1[l] + CB2[l] * mx2[l]
                - CA1[l] * my1[l] - CA2[l] * my2[l];
          r   = sum >>> 14;
          hit = 1'b0;
          if (SAT) begin
            if (r > 32767)       begin y = 32767;  hit = 1'b1; end
            else if (r < -32768) begin y = -32768; hit = 1'b1; end
            else                 y = r;
          end else begin
            y = $signed(r[15:0]);
          end
          mexp[l]    <= y;
          msat[l]    <= msat[l] | hit;
          mx2[l]     <= mx1[l];
          mx1[l]     <= x;
          my2[l]     <= my1[l];
          my1[l]     <= y;
          mpend[l]   <= 1'b1;
          pop_cyc[l] <= cyc;
          pop_cnt[l] <= pop_cnt[l] + 1;
        end
        if (out_valid[l]) begin
          if (!mpend[l]) check($sformatf("unexpected_output_l%0d", l), 1, 0);
          else           check($sformatf("data_l%0d", l), $signed(out_data[l]), mexp[l]);
        end
        if (out_valid[l] && out_ready[l] && mpend[l]) begin
          check($sformatf("sat_flag_l%0d", l), sat_flag[l], msat[l]);
          out_log[l][out_cnt[l] % 64] <= $signed(out_data[l]);
          out_cnt[l] <= out_cnt[l] + 1;
          mpend[l]   <= 1'b0;
        end
        prev_valid[l] <= out_valid[l];
        prev_acc[l]   <= out_valid[l] & out_ready[l];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int base [NL];
  int pbase [NL];

  task automatic snap();
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      base[l]  = out_cnt[l];
      pbase[l] = pop_cnt[l];
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (n < budget && !(fifo_empty == '1 && out_valid == '0 && busy == '0)) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < budget, 1);
    @(negedge clk);
  endtask

  task automatic check_log(input int l, input int k, input logic signed [63:0] exp);
    check($sformatf("directed_l%0d_out%0d", l, k), out_log[l][(base[l] + k) % 64], exp);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic signed [15:0] v;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rd_en", fifo_rd_en, 0);
    check("reset_sat_flag", sat_flag, 0);
    check("reset_out_data0", out_data[0], 0);
    @(posedge clk); #1 rst = 1'b0;

    // empty FIFO: never a pop
    repeat (30) begin
      @(negedge clk);
      check("empty_no_pop", fifo_rd_en, 0);
    end

    // directed sequences from the datasheet examples
    snap();
    @(posedge clk); #1;
    out_ready = '1;
    push(0, 16384); push(0, 0); push(0, 0); push(0, 0);
    push(1, -16'sd32768); push(1, 16'sd12345);
    push(2, 16384); push(2, 0); push(2, 0);
    push(3, 30000); push(3, 30000); push(3, 30000);
    for (int k = 0; k < 6; k++) push(4, 16'($urandom));
    wait_drain(2000);
    check_log(0, 0, 4096); check_log(0, 1, 8192); check_log(0, 2, 4096); check_log(0, 3, 0);
    check_log(1, 0, -32768); check_log(1, 1, 12345);
    check("passthrough_pops", pop_cnt[1] - pbase[1], 2);
    check_log(2, 0, 16384); check_log(2, 1, 8192); check_log(2, 2, 4096);
    check_log(3, 0, 30000);
    check_log(3, 1, SAT ? 32767 : -5536);
    check_log(3, 2, SAT ? 32767 : 24464);
    check("sat_flag_lane3", sat_flag[3], SAT ? 1 : 0);
    check("lane4_outputs", out_cnt[4] - base[4], 6);

    // backpressure on lane 0
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    for (int k = 0; k < 3; k++) push(0, 16'($urandom));
    n = 0;
    @(negedge clk);
    while (n < 50 && !out_valid[0]) begin @(negedge clk); n++; end
    check("bp_valid_timeout", n < 50, 1);
    repeat (20) begin
      @(negedge clk);
      check("bp_rd_en", fifo_rd_en[0], 0);
      check("bp_valid", out_valid[0], 1);
      check("bp_data", $signed(out_data[0]), mexp[0]);
    end
    @(posedge clk); #1 out_ready[0] = 1'b1;
    wait_drain(500);

    // randomized traffic with random backpressure and occasional clr
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      clr = ($urandom_range(0, 299) == 0);
      for (int l = 0; l < NL; l++) begin
        out_ready[l] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0 && 8'(tail[l] - head[l]) < 8'd200) begin
          case ($urandom_range(0, 3))
            0: v = -16'sd32768;
            1: v = 16'sd32767;
            default: v = 16'($urandom);
          endcase
          push(l, v);
        end
      end
    end
    @(posedge clk); #1;
    clr = 1'b0;
    out_ready = '1;
    wait_drain(3000);

    // reset in the middle of MAC2, then confirm the history is cleared
    @(posedge clk); #1 push(0, 1234);
    n = 0;
    @(negedge clk);
    while (n < 20 && !fifo_rd_en[0]) begin @(negedge clk); n++; end
    check("mid_pop_timeout", n < 20, 1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", fifo_rd_en, 0);
    check("midrst_out_data0", out_data[0], 0);
    check("midrst_sat_flag", sat_flag, 0);
    @(posedge clk); #1 rst = 1'b0;
    snap();
    @(posedge clk); #1;
    push(0, 16384); push(0, 0); push(0, 0); push(0, 0);
    wait_drain(500);
    check_log(0, 0, 4096); check_log(0, 1, 8192); check_log(0, 2, 4096); check_log(0, 3, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
